// File: rtl/prbs7_checker.sv
// -----------------------------------------------------------------------------
// prbs7_checker
//   Self-synchronising PRBS-7 (x^7 + x^6 + 1) serial checker.
//
//   The checker hunts for lock on the received bit stream. Once it is locked,
//   every mismatched bit produces a one-cycle PRBS_error pulse. The block also
//   provides a lock flag and a saturating mismatch count for debug.
//
// Ports
//   clk        in   1      system clock; all logic runs on the rising edge
//   reset      in   1      asynchronous, active-high reset
//   din        in   1      received serial bit
//   din_valid  in   1      din is sampled only on cycles where this is high
//   err_clr    in   1      synchronous clear of err_count (wins over increment)
//   PRBS_error out  1      one-cycle pulse per mismatched bit while locked
//   locked     out  1      high while in the LOCKED state
//   err_count  out  CNT_W  saturating count of mismatches seen while locked
// -----------------------------------------------------------------------------
module prbs7_checker #(
  parameter int LOCK_CNT    = 16,  // consecutive qualifying matches to lock
  parameter int WIN_LEN     = 64,  // valid bits per loss-of-lock window (>= 2)
  parameter int UNLOCK_ERRS = 8,   // mismatches in one window that drop lock
  parameter int CNT_W       = 16   // width of err_count
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             PRBS_error,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q,      state_d;
  logic [6:0]       sr_q,         sr_d;
  logic [GW-1:0]    good_cnt_q,   good_cnt_d;
  logic [WW-1:0]    win_cnt_q,    win_cnt_d;
  logic [BW-1:0]    bad_cnt_q,    bad_cnt_d;
  logic             locked_q,     locked_d;
  logic             prbs_error_q, prbs_error_d;
  logic [CNT_W-1:0] err_count_q,  err_count_d;

  logic          pred;
  logic          match;
  logic [BW-1:0] bad_inc;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    good_cnt_d   = good_cnt_q;
    win_cnt_d    = win_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    locked_d     = locked_q;
    prbs_error_d = 1'b0;
    err_count_d  = err_count_q;

    pred    = sr_q[6] ^ sr_q[5];
    match   = (din == pred);
    // Bad count including the bit currently being sampled.
    bad_inc = bad_cnt_q + BW'(!match);

    if (err_clr) begin
      err_count_d = '0;
    end

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          // While hunting, the receiver register is fed from the line.
          sr_d = {sr_q[5:0], din};
          // sr == 0 is excluded so an all-zero line can never lock.
          if (match && (sr_q != 7'd0)) begin
            if (good_cnt_q == GW'(LOCK_CNT - 1)) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              good_cnt_d = '0;
              win_cnt_d  = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + GW'(1);
            end
          end else begin
            good_cnt_d = '0;
          end
        end

        LOCKED: begin
          // Free-running generator: a single line error only counts once
          // instead of poisoning the next two predictions.
          sr_d = {sr_q[5:0], pred};

          if (!match) begin
            prbs_error_d = 1'b1;
            if (!err_clr && (err_count_q != {CNT_W{1'b1}})) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
          end

          // The current bit is counted into the window before it closes.
          if (win_cnt_q == WW'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            bad_cnt_d = bad_inc;
          end

          // Loss of lock overrides the window-end clear on the same bit.
          if (bad_inc == BW'(UNLOCK_ERRS)) begin
            state_d    = HUNT;
            locked_d   = 1'b0;
            good_cnt_d = '0;
            sr_d       = {sr_q[5:0], din};
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      locked_q     <= 1'b0;
      prbs_error_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      good_cnt_q   <= good_cnt_d;
      win_cnt_q    <= win_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      locked_q     <= locked_d;
      prbs_error_q <= prbs_error_d;
      err_count_q  <= err_count_d;
    end
  end

  assign PRBS_error = prbs_error_q;
  assign locked     = locked_q;
  assign err_count  = err_count_q;

endmodule
